// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared widths, FSM encoding and job record for stage 2
package stage_pkg;

    localparam int FLT_DATA_WIDTH    = 32;
    localparam int CORDIC_DATA_WIDTH = 22;

    typedef logic [CORDIC_DATA_WIDTH-1:0] cordic_t;
    typedef logic [FLT_DATA_WIDTH-1:0]    flt_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE_ONE = 3'd1,
        ST_WAIT_ONE  = 3'd2,
        ST_ISSUE_TWO = 3'd3,
        ST_WAIT_TWO  = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

    typedef struct packed {
        cordic_t op_one;
        cordic_t op_two;
        flt_t    half_one;
        flt_t    half_two;
        flt_t    square_one;
        flt_t    square_two;
    } job_t;

    localparam int JOB_WIDTH = $bits(job_t);

endpackage

// File: rtl/stage_2_if.sv
// rtl/stage_2_if.sv - job, CORDIC-core and result signals of stage 2
interface stage_2_if;
    import stage_pkg::*;

    logic    start;
    cordic_t in_one;
    cordic_t in_two;
    flt_t    half_in_one;
    flt_t    half_in_two;
    flt_t    square_in_one;
    flt_t    square_in_two;

    logic    cordic_start;
    cordic_t cordic_x;
    logic    cordic_done;
    cordic_t cordic_result;

    logic    done;
    cordic_t res_one;
    cordic_t res_two;
    flt_t    half_out_one;
    flt_t    half_out_two;
    flt_t    square_out_one;
    flt_t    square_out_two;
    logic    busy;
    logic    overflow;

    modport slave (
        input  start, in_one, in_two, half_in_one, half_in_two,
               square_in_one, square_in_two, cordic_done, cordic_result,
        output cordic_start, cordic_x, done, res_one, res_two,
               half_out_one, half_out_two, square_out_one, square_out_two,
               busy, overflow
    );

    modport master (
        output start, in_one, in_two, half_in_one, half_in_two,
               square_in_one, square_in_two, cordic_done, cordic_result,
        input  cordic_start, cordic_x, done, res_one, res_two,
               half_out_one, half_out_two, square_out_one, square_out_two,
               busy, overflow
    );

endinterface

// File: rtl/stage_2_job_buffer.sv
// rtl/stage_2_job_buffer.sv - one-entry skid buffer for a pending job
module stage_2_job_buffer
    import stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic load_i,
    input  logic pop_i,
    input  job_t data_i,
    output job_t data_o,
    output logic valid_o
);

    logic valid_q, valid_d;
    job_t data_q, data_d;

    // Load beats pop so a new job can refill the slot being drained.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clk_en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/stage_2.sv
// rtl/stage_2.sv - sequences two operands through a shared CORDIC core per job
module stage_2
    import stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clk_en,
    stage_2_if.slave bus
);

    state_e  state_q, state_d;
    job_t    active_q, active_d;
    job_t    out_q, out_d;
    cordic_t stage_one_q, stage_one_d;
    cordic_t stage_two_q, stage_two_d;
    logic    done_q, done_d;
    logic    overflow_q, overflow_d;
    logic    cordic_start;
    logic    buf_load, buf_pop, buf_valid;
    job_t    buf_data, in_job;

    assign in_job = '{op_one:     bus.in_one,
                      op_two:     bus.in_two,
                      half_one:   bus.half_in_one,
                      half_two:   bus.half_in_two,
                      square_one: bus.square_in_one,
                      square_two: bus.square_in_two};

    stage_2_job_buffer u_job_buffer (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .load_i  (buf_load),
        .pop_i   (buf_pop),
        .data_i  (in_job),
        .data_o  (buf_data),
        .valid_o (buf_valid)
    );

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        out_d        = out_q;
        stage_one_d  = stage_one_q;
        stage_two_d  = stage_two_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        cordic_start = 1'b0;
        buf_load     = 1'b0;
        buf_pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (buf_valid) begin
                    active_d = buf_data;
                    buf_pop  = 1'b1;
                    state_d  = ST_ISSUE_ONE;
                end else if (bus.start) begin
                    active_d = in_job;
                    state_d  = ST_ISSUE_ONE;
                end
            end
            ST_ISSUE_ONE: begin
                cordic_start = 1'b1;
                state_d      = ST_WAIT_ONE;
            end
            ST_WAIT_ONE: begin
                if (bus.cordic_done) begin
                    stage_one_d = bus.cordic_result;
                    state_d     = ST_ISSUE_TWO;
                end
            end
            ST_ISSUE_TWO: begin
                cordic_start = 1'b1;
                state_d      = ST_WAIT_TWO;
            end
            ST_WAIT_TWO: begin
                if (bus.cordic_done) begin
                    stage_two_d = bus.cordic_result;
                    state_d     = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // The op fields of the output record carry the two results.
                out_d = '{op_one:     stage_one_q,
                          op_two:     stage_two_q,
                          half_one:   active_q.half_one,
                          half_two:   active_q.half_two,
                          square_one: active_q.square_one,
                          square_two: active_q.square_two};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start not taken directly by IDLE goes to the buffer or is lost.
        if (bus.start && !(state_q == ST_IDLE && !buf_valid)) begin
            if (!buf_valid || buf_pop) begin
                buf_load = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            out_q       <= '0;
            stage_one_q <= '0;
            stage_two_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            active_q    <= active_d;
            out_q       <= out_d;
            stage_one_q <= stage_one_d;
            stage_two_q <= stage_two_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.cordic_start   = cordic_start;
    assign bus.cordic_x       = (state_q == ST_ISSUE_TWO || state_q == ST_WAIT_TWO)
                                ? active_q.op_two : active_q.op_one;
    assign bus.done           = done_q;
    assign bus.res_one        = out_q.op_one;
    assign bus.res_two        = out_q.op_two;
    assign bus.half_out_one   = out_q.half_one;
    assign bus.half_out_two   = out_q.half_two;
    assign bus.square_out_one = out_q.square_one;
    assign bus.square_out_two = out_q.square_two;
    assign bus.busy           = (state_q != ST_IDLE) || buf_valid;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_stage_2.sv
// tb/tb_stage_2.sv - directed vector bench for stage_2 with an L=3 CORDIC model
module tb_stage_2;

    localparam int L   = 3;
    localparam int LAT = 2 * L + 4;

    typedef struct {
        logic [21:0] in_one;
        logic [21:0] in_two;
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [21:0] exp_one;
        logic [21:0] exp_two;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        spur = 1'b0;
    logic [3:0]  cnt = 4'd0;
    logic [21:0] x_cap = 22'd0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          n_done = 0;
    int          n_cs = 0;
    vec_t        tbl[4];

    stage_2_if bus ();

    stage_2 dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Core model: result valid L enabled cycles after the start is sampled.
    always @(posedge clk) begin
        if (clk_en) begin
            if (bus.cordic_start) begin
                cnt   <= 4'(L);
                x_cap <= bus.cordic_x;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (bus.done)         n_done = n_done + 1;
            if (bus.cordic_start) n_cs   = n_cs + 1;
        end
    end

    assign bus.cordic_done   = (cnt == 4'd1) || spur;
    assign bus.cordic_result = x_cap + 22'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.in_one        = v.in_one;
        bus.in_two        = v.in_two;
        bus.half_in_one   = v.h1;
        bus.half_in_two   = v.h2;
        bus.square_in_one = v.s1;
        bus.square_in_two = v.s2;
    endtask

    // Drives start for one edge; returns at the negedge of cycle 1.
    task automatic start_job(input vec_t v);
        set_in(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 60);
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, "_res_one"}, 64'(bus.res_one), 64'(v.exp_one));
        chk({tag, "_res_two"}, 64'(bus.res_two), 64'(v.exp_two));
        chk({tag, "_half1"},   64'(bus.half_out_one),   64'(v.h1));
        chk({tag, "_half2"},   64'(bus.half_out_two),   64'(v.h2));
        chk({tag, "_sq1"},     64'(bus.square_out_one), 64'(v.s1));
        chk({tag, "_sq2"},     64'(bus.square_out_two), 64'(v.s2));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_res_one"}, 64'(bus.res_one), 64'd0);
        chk({tag, "_res_two"}, 64'(bus.res_two), 64'd0);
        chk({tag, "_half1"},   64'(bus.half_out_one), 64'd0);
        chk({tag, "_sq2"},     64'(bus.square_out_two), 64'd0);
        chk({tag, "_done"},    64'(bus.done), 64'd0);
        chk({tag, "_busy"},    64'(bus.busy), 64'd0);
        chk({tag, "_ovf"},     64'(bus.overflow), 64'd0);
        chk({tag, "_cstart"},  64'(bus.cordic_start), 64'd0);
        chk({tag, "_cx"},      64'(bus.cordic_x), 64'd0);
    endtask

    task automatic run_single(input string tag, input vec_t v);
        int cs0, dn0, cyc;
        cs0 = n_cs;
        dn0 = n_done;
        start_job(v);
        wait_done(cyc);
        chk({tag, "_latency"}, 64'(1 + cyc), 64'(LAT));
        chk_out(tag, v);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(bus.done), 64'd0);
        chk({tag, "_n_cstart"}, 64'(n_cs - cs0), 64'd2);
        chk({tag, "_n_done"}, 64'(n_done - dn0), 64'd1);
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int cyc, dn0;

        tbl[0] = '{22'h000100, 22'h0000FF, 32'h3F000000, 32'h3E800000,
                   32'h3E800000, 32'h40800000, 22'h000101, 22'h000100};
        tbl[1] = '{22'h3FFFFF, 22'h000000, 32'hFFFFFFFF, 32'h00000001,
                   32'h80000000, 32'h7F800000, 22'h000000, 22'h000001};
        tbl[2] = '{22'h1FFFFF, 22'h2AAAAA, 32'h12345678, 32'h9ABCDEF0,
                   32'h0F0F0F0F, 32'hF0F0F0F0, 22'h200000, 22'h2AAAAB};
        tbl[3] = '{22'h155555, 22'h3FFFFE, 32'hC0490FDB, 32'h40490FDB,
                   32'h41200000, 32'hC1200000, 22'h155556, 22'h3FFFFF};

        bus.start = 1'b0;
        set_in(tbl[0]);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_single($sformatf("vec%0d", i), tbl[i]);
        end

        // Three starts two cycles apart: second buffered, third dropped.
        dn0 = n_done;
        start_job(tbl[0]);
        @(negedge clk);
        start_job(tbl[1]);
        @(negedge clk);
        start_job(tbl[2]);
        wait_done(cyc);
        chk("b2b_lat1", 64'(5 + cyc), 64'(LAT));
        chk_out("b2b_job1", tbl[0]);
        wait_done(cyc);
        chk("b2b_lat2", 64'(cyc), 64'(LAT));
        chk_out("b2b_job2", tbl[1]);
        repeat (30) @(negedge clk);
        chk("b2b_n_done", 64'(n_done - dn0), 64'd2);
        chk("b2b_overflow", 64'(bus.overflow), 64'd1);
        chk("b2b_busy", 64'(bus.busy), 64'd0);

        // clk_en low for 5 cycles while waiting on the first result.
        start_job(tbl[3]);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_cx", 64'(bus.cordic_x), 64'(tbl[3].in_one));
            chk("stall_res", 64'(bus.res_one), 64'(tbl[1].exp_one));
            chk("stall_done", 64'(bus.done), 64'd0);
        end
        clk_en = 1'b1;
        wait_done(cyc);
        chk("stall_latency", 64'(7 + cyc), 64'(LAT + 5));
        chk_out("stall", tbl[3]);

        // Reset in WAIT_TWO, then the core's late result arrives.
        @(negedge clk);
        start_job(tbl[2]);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        dn0 = n_done;
        repeat (12) @(negedge clk);
        chk("late_n_done", 64'(n_done - dn0), 64'd0);
        chk("late_busy", 64'(bus.busy), 64'd0);
        chk("late_res_one", 64'(bus.res_one), 64'd0);
        run_single("post_rst", tbl[0]);

        // Spurious core pulse in IDLE, then a start during FINISH.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_busy", 64'(bus.busy), 64'd0);
        chk("spur_res_one", 64'(bus.res_one), 64'(tbl[0].exp_one));
        start_job(tbl[1]);
        repeat (8) @(negedge clk);
        set_in(tbl[3]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("fin_done_a", 64'(bus.done), 64'd1);
        chk_out("fin_job_a", tbl[1]);
        wait_done(cyc);
        chk("fin_lat_b", 64'(cyc), 64'(LAT));
        chk_out("fin_job_b", tbl[3]);
        chk("fin_overflow", 64'(bus.overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stage_2.md
Name: stage_2

Overview:
- Downstream neighbour of the stage-1 pre-processing block.
- Accepts one job per stage-1 done pulse. A job is two CORDIC-format operands plus their float half and square values.
- Time-multiplexes a single shared iterative CORDIC core over both operands, one after the other, then presents both results aligned with the forwarded half/square floats and pulses done.
- Holds one extra job in a skid buffer, because stage 1 has no back-pressure.

Parameters:
- FLT_DATA_WIDTH, 32, float word width for half/square passthrough
- CORDIC_DATA_WIDTH, 22, fixed-point operand/result width of the CORDIC core

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- clk_en  input  1  global clock enable; no state advances when low
- start  input  1  job strobe, driven by stage-1 done
- in_one, in_two  input  CORDIC_DATA_WIDTH  operands for the CORDIC core
- half_in_one, half_in_two  input  FLT_DATA_WIDTH  halved floats, passthrough
- square_in_one, square_in_two  input  FLT_DATA_WIDTH  squared floats, passthrough
- cordic_start  output  1  one-cycle request to the CORDIC core
- cordic_x  output  CORDIC_DATA_WIDTH  operand presented to the core
- cordic_done  input  1  core result-valid pulse
- cordic_result  input  CORDIC_DATA_WIDTH  core result
- done  output  1  one-cycle job-complete pulse
- res_one, res_two  output  CORDIC_DATA_WIDTH  CORDIC results for operand one and operand two
- half_out_one, half_out_two, square_out_one, square_out_two  output  FLT_DATA_WIDTH  passthrough values, aligned with the results
- busy  output  1  high whenever the FSM is not IDLE or the buffer is occupied
- overflow  output  1  sticky: a job was dropped

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0.
  - FSM goes to IDLE; buffer is emptied.
  - Any in-flight job is discarded, and a late cordic_done after reset is ignored.
- Gating: every register update is qualified by clk_en. The CORDIC core shares clk_en, so cordic_done is sampled only when clk_en is high.
- Job capture (on a clk_en posedge with start high):
  - FSM in IDLE and buffer empty: load the active registers directly and go to ISSUE_ONE.
  - Otherwise, buffer empty: load the buffer.
  - Otherwise: drop the job and set overflow; it stays set until reset.
- FSM states: IDLE, ISSUE_ONE, WAIT_ONE, ISSUE_TWO, WAIT_TWO, FINISH.
  - IDLE: if the buffer is valid, move the buffer into the active registers, clear the buffer, go to ISSUE_ONE. Otherwise wait for start.
  - ISSUE_ONE: cordic_start=1 for exactly one cycle with cordic_x=active operand one; go to WAIT_ONE.
  - WAIT_ONE: on cordic_done, capture cordic_result into the res_one staging register; go to ISSUE_TWO.
  - ISSUE_TWO / WAIT_TWO: same as above for operand two; on cordic_done go to FINISH.
  - FINISH: update res_one, res_two and the four float outputs together; done=1 for one cycle; go to IDLE.
- cordic_done in any state other than WAIT_* is ignored.
- Latency: with a core latency of L cycles (cordic_start to cordic_done), done rises 2L+4 cycles after the start edge. Back-to-back jobs from the buffer add 1 cycle each (the IDLE hop).
- Output stability: the outputs hold the last completed job's values until the next FINISH.
- cordic_start is low everywhere except the two ISSUE states.
- cordic_x holds its value from ISSUE until the matching cordic_done.
- Simultaneous events:
  - A start in the same cycle that IDLE drains the buffer goes into the freed buffer slot (no overflow).
  - A start during FINISH is buffered normally.
- No arithmetic is performed. Values pass through bit-exact; widths are unchanged.

Decomposition:
- Shared package stage_pkg holds:
  - FLT_DATA_WIDTH, CORDIC_DATA_WIDTH
  - FSM state encodings
  - a job record grouping the 2 operands and 4 floats (2*CORDIC_DATA_WIDTH + 4*FLT_DATA_WIDTH = 172 bits)
- One sub-module: stage_2_job_buffer.
  - One-entry holding register with valid flag.
  - Ports: load, pop, data in/out, valid.
  - The same async active-low rst and clk_en as the parent.

Test Plan:
- Single job, CORDIC model with L=3 returning operand+1:
  - Stimulus: in_one=22'h000100, in_two=22'h0000FF, half_in_one=32'h3F000000, square_in_two=32'h40800000.
  - Required: res_one=22'h000101, res_two=22'h000100; half/square outputs bit-exact; done for exactly 1 cycle at the 10th edge after start; exactly two cordic_start pulses.
- Back-to-back: three start pulses 2 cycles apart.
  - Required: jobs 1 and 2 complete in order; job 3 is dropped; overflow=1; exactly two done pulses.
- clk_en low for 5 cycles during WAIT_ONE, with the core model stalled the same way.
  - Required: state and outputs frozen; done delayed by exactly 5 cycles; results are still correct.
- rst asserted mid-WAIT_TWO, then a late cordic_done.
  - Required: all outputs 0 immediately (asynchronously), busy=0, no done, late cordic_done ignored.
  - A fresh job after reset completes normally.
- Spurious cordic_done while in IDLE, and start while in FINISH.
  - Required: spurious pulse ignored; job from FINISH buffered and completed; overflow stays 0.
